// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed seven-segment digit scanner with double buffer, blanking and dead time
module seven_segment_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [3:0]            digit_value,
  output logic                  digit_dp,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_done
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [TW-1:0]         tick_q, tick_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [3:0]            digit_value_q, digit_value_d;
  logic                  digit_dp_q, digit_dp_d;
  logic [DIGITS-1:0]     anode_n_q, anode_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick_wrap, frame_wrap;
  logic                  zero_above;
  logic [DIGITS-1:0]     blank;

  assign tick_wrap  = (tick_q == TW'(REFRESH_DIV - 1));
  assign frame_wrap = tick_wrap && (idx_q == IW'(DIGITS - 1));

  // Walk down from the most significant digit; a digit is blankable while
  // it and everything above it is a zero nibble without a decimal point.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (act_val_q[4*k +: 4] == 4'd0) & ~act_dp_q[k];
      blank[k]   = lz_en & zero_above & (k != 0);
    end
  end

  always_comb begin
    tick_d        = tick_wrap ? '0 : tick_q + 1'b1;
    idx_d         = idx_q;
    pend_val_d    = pend_val_q;
    pend_dp_d     = pend_dp_q;
    act_val_d     = act_val_q;
    act_dp_d      = act_dp_q;
    if (tick_wrap) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
    end
    // Active only changes at the frame boundary, so a frame never tears.
    if (frame_wrap) begin
      act_val_d = pend_val_d;
      act_dp_d  = pend_dp_d;
    end
    digit_value_d = act_val_q[{idx_q, 2'b00} +: 4];
    digit_dp_d    = act_dp_q[idx_q];
    if ((tick_q < TW'(DEAD)) || blank[idx_q]) begin
      anode_n_d = '1;
    end else begin
      anode_n_d = ~(DIGITS'(1) << idx_q);
    end
    frame_done_d  = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= '0;
      idx_q         <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      digit_value_q <= '0;
      digit_dp_q    <= 1'b0;
      anode_n_q     <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      digit_value_q <= digit_value_d;
      digit_dp_q    <= digit_dp_d;
      anode_n_q     <= anode_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign digit_value = digit_value_q;
  assign digit_dp    = digit_dp_q;
  assign anode_n     = anode_n_q;
  assign frame_done  = frame_done_q;

endmodule
